// File: rtl/i2s_audio_tx.sv
// I2S transmitter: a fractional phase accumulator paces the bclk edges so the long-term
// frame rate is exact; one L/R pair is latched per frame and shifted out MSB first.
module i2s_audio_tx #(
    parameter int CLK_HZ      = 32000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int BITS        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] audio_l,
    input  logic [15:0] audio_r,
    input  logic        mute,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_din,
    output logic        sample_strobe
);
    localparam int INC = 2 * SAMPLE_RATE * 2 * BITS;
    localparam int NW  = $clog2(2 * BITS);
    localparam int BW  = $clog2(BITS);
    localparam logic [NW-1:0] N_LAST = NW'(2 * BITS - 1);
    localparam logic [NW-1:0] N_HALF = NW'(BITS);

    generate
        if (INC >= CLK_HZ || BITS < 2 || BITS > 32) begin : g_bad_cfg
            $error("i2s_audio_tx: bit-clock increment must be below CLK_HZ and BITS in 2..32");
        end
    endgenerate

    logic [31:0]     acc_reg;
    logic            bclk_reg;
    logic            lrck_reg;
    logic            din_reg;
    logic            strobe_reg;
    logic [NW-1:0]   n_reg;
    logic [BITS-1:0] l_reg;
    logic [BITS-1:0] r_reg;

    logic [32:0]     sum;
    logic            tick;
    logic [31:0]     acc_next;
    logic [NW-1:0]   n_next;
    logic [BW-1:0]   idx_l;
    logic [BW-1:0]   idx_r;
    logic            lrck_next;
    logic            din_next;
    logic [31:0]     l_wide;
    logic [31:0]     r_wide;
    logic [BITS-1:0] l_in;
    logic [BITS-1:0] r_in;

    // Carry-out of the accumulator marks one bclk half-period boundary.
    assign sum      = {1'b0, acc_reg} + 33'(INC);
    assign tick     = (sum >= 33'(CLK_HZ));
    assign acc_next = tick ? 32'(sum - 33'(CLK_HZ)) : sum[31:0];

    assign n_next    = (n_reg == N_LAST) ? '0 : n_reg + NW'(1);
    assign idx_l     = BW'(N_HALF - n_next);
    assign idx_r     = BW'((NW+1)'(2 * BITS) - {1'b0, n_next});
    assign lrck_next = (n_next >= N_HALF);

    // Samples are left-aligned into the slot so wider slots pad with zeros.
    assign l_wide = {audio_l, 16'h0000};
    assign r_wide = {audio_r, 16'h0000};
    assign l_in   = mute ? '0 : l_wide[31 -: BITS];
    assign r_in   = mute ? '0 : r_wide[31 -: BITS];

    // At n=0 the outgoing bit is still the previous frame's R LSB.
    always_comb begin
        if (n_next == '0) begin
            din_next = r_reg[0];
        end else if (n_next <= N_HALF) begin
            din_next = l_reg[idx_l];
        end else begin
            din_next = r_reg[idx_r];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg    <= '0;
            bclk_reg   <= 1'b0;
            lrck_reg   <= 1'b0;
            din_reg    <= 1'b0;
            strobe_reg <= 1'b0;
            n_reg      <= N_LAST;
            l_reg      <= '0;
            r_reg      <= '0;
        end else begin
            acc_reg    <= acc_next;
            strobe_reg <= 1'b0;
            if (tick) begin
                bclk_reg <= ~bclk_reg;
                if (bclk_reg) begin
                    n_reg    <= n_next;
                    lrck_reg <= lrck_next;
                    din_reg  <= din_next;
                    if (n_next == '0) begin
                        l_reg      <= l_in;
                        r_reg      <= r_in;
                        strobe_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign i2s_bclk      = bclk_reg;
    assign i2s_lrck      = lrck_reg;
    assign i2s_din       = din_reg;
    assign sample_strobe = strobe_reg;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: a frame-level model turns each latched L/R pair into the
// expected one-bit-delayed serial stream and checks every bclk edge against it.
module tb_i2s_audio_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] audio_l = 16'h0000;
    logic [15:0] audio_r = 16'h0000;
    logic        mute = 1'b0;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_din;
    logic        sample_strobe;

    int n_cmp = 0;
    int n_bad = 0;

    i2s_audio_tx dut (
        .clk           (clk),
        .reset         (reset),
        .audio_l       (audio_l),
        .audio_r       (audio_r),
        .mute          (mute),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrck      (i2s_lrck),
        .i2s_din       (i2s_din),
        .sample_strobe (sample_strobe)
    );

    always #5 clk = ~clk;

    // Model state: inputs seen at the last active edge, and the expected serial bits.
    logic [15:0] snap_l = 16'h0000;
    logic [15:0] snap_r = 16'h0000;
    logic        snap_m = 1'b0;
    logic        snap_rst = 1'b1;
    logic        prev_bclk = 1'b0;
    int          half_cnt = 0;
    int          fall_cnt = 0;
    int          pos = 0;
    bit          pre_strobe = 1'b1;
    int          strobe_total = 0;
    int          done_cnt = 0;
    int          rate_strobes = 0;
    int          rate_rises = 0;
    logic [31:0] vec = 32'h0;
    logic [31:0] frames [0:255];
    bit          exp_bits [$];
    bit          prev_r0 = 1'b0;

    always @(posedge clk) begin
        snap_l   = audio_l;
        snap_r   = audio_r;
        snap_m   = mute;
        snap_rst = reset;
    end

    always @(negedge clk) begin : monitor
        logic [15:0] ml, mr;
        bit exp_din, exp_lrck, exp_strobe, have_exp;
        if (reset || snap_rst) begin
            prev_bclk    = 1'b0;
            half_cnt     = 0;
            fall_cnt     = 0;
            pos          = 0;
            pre_strobe   = 1'b1;
            prev_r0      = 1'b0;
            rate_strobes = 0;
            rate_rises   = 0;
            exp_bits.delete();
        end else begin
            if (sample_strobe === 1'b1) rate_strobes++;
            half_cnt++;
            if (i2s_bclk !== prev_bclk) begin
                n_cmp++;
                if (half_cnt < 10 || half_cnt > 11) begin
                    n_bad++;
                    $display("FAIL half_period: got %0d clks, want 10 or 11", half_cnt);
                end
                half_cnt = 0;
                if (i2s_bclk === 1'b1) begin
                    rate_rises++;
                    have_exp = 1'b1;
                    if (pre_strobe) begin
                        exp_din  = 1'b0;
                        exp_lrck = 1'b0;
                    end else begin
                        pos++;
                        exp_lrck = (pos >= 16);
                        exp_din  = 1'b0;
                        if (exp_bits.size() == 0) begin
                            have_exp = 1'b0;
                            n_cmp++;
                            n_bad++;
                            $display("FAIL rise_no_frame: got rising edge at pos %0d, want a frame start first", pos);
                        end else begin
                            exp_din = exp_bits.pop_front();
                        end
                        vec = {vec[30:0], i2s_din};
                        if (pos == 31) begin
                            frames[strobe_total % 256] = vec;
                            done_cnt = strobe_total;
                        end
                    end
                    if (have_exp) begin
                        n_cmp++;
                        if (i2s_din !== exp_din) begin
                            n_bad++;
                            $display("FAIL din_at_rise: got %b want %b (frame %0d pos %0d)", i2s_din, exp_din, strobe_total, pos);
                        end
                    end
                    n_cmp++;
                    if (i2s_lrck !== exp_lrck) begin
                        n_bad++;
                        $display("FAIL lrck_at_rise: got %b want %b (pos %0d)", i2s_lrck, exp_lrck, pos);
                    end
                end else begin
                    exp_strobe = ((fall_cnt % 32) == 0);
                    exp_lrck   = ((fall_cnt % 32) >= 16);
                    n_cmp++;
                    if (sample_strobe !== exp_strobe) begin
                        n_bad++;
                        $display("FAIL strobe_at_fall: got %b want %b (falling edge %0d)", sample_strobe, exp_strobe, fall_cnt);
                    end
                    n_cmp++;
                    if (i2s_lrck !== exp_lrck) begin
                        n_bad++;
                        $display("FAIL lrck_at_fall: got %b want %b (falling edge %0d)", i2s_lrck, exp_lrck, fall_cnt);
                    end
                    fall_cnt++;
                    if (exp_strobe) begin
                        ml = snap_m ? 16'h0000 : snap_l;
                        mr = snap_m ? 16'h0000 : snap_r;
                        exp_bits.push_back(prev_r0);
                        for (int i = 15; i >= 0; i--) exp_bits.push_back(ml[i]);
                        for (int i = 15; i >= 1; i--) exp_bits.push_back(mr[i]);
                        prev_r0 = mr[0];
                        strobe_total++;
                        pre_strobe = 1'b0;
                        pos = -1;
                    end
                end
                prev_bclk = i2s_bclk;
            end else begin
                n_cmp++;
                if (sample_strobe !== 1'b0) begin
                    n_bad++;
                    $display("FAIL strobe_stray: got %b want 0 outside a falling edge", sample_strobe);
                end
            end
        end
    end

    task automatic wait_strobes(input int target, input string what);
        int k = 0;
        while (strobe_total < target && k < 5000) begin
            @(posedge clk); #2;
            k++;
        end
        n_cmp++;
        if (strobe_total < target) begin
            n_bad++;
            $display("FAIL %s: got %0d frame starts, want %0d before timeout", what, strobe_total, target);
        end
    endtask

    task automatic wait_done(input int target, input string what);
        int k = 0;
        while (done_cnt < target && k < 5000) begin
            @(posedge clk); #2;
            k++;
        end
        n_cmp++;
        if (done_cnt < target) begin
            n_bad++;
            $display("FAIL %s: got %0d frames completed, want %0d before timeout", what, done_cnt, target);
        end
    endtask

    task automatic wait_pos(input int s, input int p, input string what);
        int k = 0;
        while (!((strobe_total > s) || (strobe_total == s && !pre_strobe && pos >= p)) && k < 5000) begin
            @(posedge clk); #2;
            k++;
        end
        n_cmp++;
        if (strobe_total < s || (strobe_total == s && pos < p)) begin
            n_bad++;
            $display("FAIL %s: got frame %0d pos %0d, want frame %0d pos %0d before timeout", what, strobe_total, pos, s, p);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #2;
        if (i2s_bclk !== 1'b0)      begin n_bad++; $display("FAIL reset_bclk: got %b want 0", i2s_bclk); end
        if (i2s_lrck !== 1'b0)      begin n_bad++; $display("FAIL reset_lrck: got %b want 0", i2s_lrck); end
        if (i2s_din !== 1'b0)       begin n_bad++; $display("FAIL reset_din: got %b want 0", i2s_din); end
        if (sample_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", sample_strobe); end
        n_cmp += 4;
        audio_l = 16'hFFFF;
        audio_r = 16'hFFFF;
        reset = 1'b0;
        repeat (700) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        if (i2s_bclk !== 1'b0)      begin n_bad++; $display("FAIL async_reset_bclk: got %b want 0", i2s_bclk); end
        if (i2s_lrck !== 1'b0)      begin n_bad++; $display("FAIL async_reset_lrck: got %b want 0", i2s_lrck); end
        if (i2s_din !== 1'b0)       begin n_bad++; $display("FAIL async_reset_din: got %b want 0", i2s_din); end
        if (sample_strobe !== 1'b0) begin n_bad++; $display("FAIL async_reset_strobe: got %b want 0", sample_strobe); end
        n_cmp += 4;
        @(posedge clk); #2;
    endtask

    // 25000 clks at 32 MHz is exactly 2400 bclk edges: 1200 rising, 38 frame starts.
    task automatic test_rate();
        audio_l = 16'($urandom);
        audio_r = 16'($urandom);
        reset = 1'b0;
        repeat (25000) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if (rate_strobes != 38) begin
            n_bad++;
            $display("FAIL rate_strobes: got %0d want 38", rate_strobes);
        end
        n_cmp++;
        if (rate_rises < 1199 || rate_rises > 1201) begin
            n_bad++;
            $display("FAIL rate_rises: got %0d want 1200 +/-1", rate_rises);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_serial();
        logic [15:0] ll, rr;
        logic [31:0] got, want;
        int s0;
        ll = 16'hA5C3;
        rr = 16'h5A3C;
        audio_l = ll;
        audio_r = rr;
        mute = 1'b0;
        s0 = strobe_total;
        wait_done(s0 + 3, "serial_wait");
        got  = frames[(s0 + 3) % 256];
        want = {rr[0], ll, rr[15:1]};
        n_cmp++;
        if (got[30:15] !== ll) begin
            n_bad++;
            $display("FAIL serial_left: got %h want %h", got[30:15], ll);
        end
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL serial_frame: got %h want %h", got, want);
        end
    endtask

    task automatic test_delay();
        logic [15:0] ll, rr;
        logic [31:0] want;
        int s0;
        ll = 16'h8000;
        rr = 16'h0000;
        audio_l = ll;
        audio_r = rr;
        s0 = strobe_total;
        wait_done(s0 + 3, "delay_wait");
        want = {rr[0], ll, rr[15:1]};
        n_cmp++;
        if (frames[(s0 + 3) % 256] !== want) begin
            n_bad++;
            $display("FAIL one_bit_delay: got %h want %h", frames[(s0 + 3) % 256], want);
        end
    endtask

    task automatic test_midframe();
        int s0;
        audio_l = 16'hFFFF;
        audio_r = 16'($urandom);
        s0 = strobe_total;
        wait_pos(s0 + 3, 5, "mid_wait_pos");
        audio_l = 16'h0000;
        wait_done(s0 + 4, "mid_wait_done");
        n_cmp++;
        if (frames[(s0 + 3) % 256][30:15] !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL mid_current: got %h want ffff", frames[(s0 + 3) % 256][30:15]);
        end
        n_cmp++;
        if (frames[(s0 + 4) % 256][30:15] !== 16'h0000) begin
            n_bad++;
            $display("FAIL mid_next: got %h want 0000", frames[(s0 + 4) % 256][30:15]);
        end
    endtask

    task automatic test_mute();
        logic [15:0] v;
        logic [31:0] want;
        int s0;
        v = 16'h7FFF;
        audio_l = v;
        audio_r = v;
        mute = 1'b0;
        s0 = strobe_total;
        wait_strobes(s0 + 3, "mute_wait_start");
        mute = 1'b1;
        wait_done(s0 + 4, "mute_wait_muted");
        want = {v[0], 16'h0000, 15'h0000};
        n_cmp++;
        if (frames[(s0 + 4) % 256] !== want) begin
            n_bad++;
            $display("FAIL mute_frame: got %h want %h", frames[(s0 + 4) % 256], want);
        end
        mute = 1'b0;
        wait_done(s0 + 5, "mute_wait_unmuted");
        want = {1'b0, v, v[15:1]};
        n_cmp++;
        if (frames[(s0 + 5) % 256] !== want) begin
            n_bad++;
            $display("FAIL unmute_frame: got %h want %h", frames[(s0 + 5) % 256], want);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] ll, rr;
        logic [31:0] want;
        int s0, s1;
        ll = 16'($urandom);
        rr = 16'($urandom);
        audio_l = ll;
        audio_r = rr;
        s0 = strobe_total;
        wait_pos(s0 + 2, 20, "rstmid_wait_pos");
        reset = 1'b1;
        #1;
        if (i2s_bclk !== 1'b0) begin n_bad++; $display("FAIL rstmid_bclk: got %b want 0", i2s_bclk); end
        if (i2s_lrck !== 1'b0) begin n_bad++; $display("FAIL rstmid_lrck: got %b want 0", i2s_lrck); end
        if (i2s_din !== 1'b0)  begin n_bad++; $display("FAIL rstmid_din: got %b want 0", i2s_din); end
        n_cmp += 3;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        s1 = strobe_total;
        wait_done(s1 + 1, "rstmid_wait_done");
        want = {1'b0, ll, rr[15:1]};
        n_cmp++;
        if (frames[(s1 + 1) % 256] !== want) begin
            n_bad++;
            $display("FAIL rstmid_first_frame: got %h want %h", frames[(s1 + 1) % 256], want);
        end
    endtask

    task automatic test_random();
        logic [15:0] ll, rr;
        logic        mm;
        logic [31:0] want;
        int s0;
        for (int i = 0; i < 12; i++) begin
            audio_l = 16'($urandom);
            audio_r = 16'($urandom);
            mute    = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(20, 900)) @(posedge clk);
            #2;
        end
        ll = 16'($urandom);
        rr = 16'($urandom);
        mm = ($urandom_range(0, 1) == 0);
        audio_l = ll;
        audio_r = rr;
        mute = mm;
        s0 = strobe_total;
        wait_done(s0 + 3, "random_wait");
        if (mm) want = 32'h0000_0000;
        else    want = {rr[0], ll, rr[15:1]};
        n_cmp++;
        if (frames[(s0 + 3) % 256] !== want) begin
            n_bad++;
            $display("FAIL random_final_frame: got %h want %h (mute %b)", frames[(s0 + 3) % 256], want, mm);
        end
        mute = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rate();
        test_serial();
        test_delay();
        test_midframe();
        test_mute();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
